as_src_mac_check: RTL and testbench
===================================

// Module: as_src_mac_check
// PURPOSE
//  Pipeline stage directly downstream of the anti-spoof output-port lookup. Inspects each packet's
//  Ethernet source MAC; drops packets whose source is multicast/broadcast (src_mac[40]=1) or all-zero,
//  forwards all others unchanged. Counts passed and dropped packets. Uses standard in_*/out_* handshake.
// PARAMETERS
//  DATA_WIDTH          64  datapath width; only 64 is supported (MAC field offsets fixed)
//  CTRL_WIDTH          8   DATA_WIDTH/8
//  IN_FIFO_DEPTH_BITS  4   log2 depth of the word buffer; must hold all module headers plus two data words
//  DEC_FIFO_DEPTH_BITS 2   log2 depth of the per-packet decision FIFO
//  CNT_WIDTH           32  width of the pass and drop counters
// PORTS
//  clk          in   1           clock
//  reset        in   1           asynchronous, active-low reset
//  in_data      in   DATA_WIDTH  upstream word
//  in_ctrl      in   CTRL_WIDTH  upstream ctrl (!=0: module header or eop marker; 0: packet data)
//  in_wr        in   1           upstream write strobe
//  in_rdy       out  1           !in_fifo_nearly_full && !dec_fifo_nearly_full
//  out_data     out  DATA_WIDTH  head of word buffer
//  out_ctrl     out  CTRL_WIDTH  head of word buffer
//  out_wr       out  1           downstream write strobe
//  out_rdy      in   1           downstream ready
//  check_en     in   1           1: apply filter; 0: pass every packet (sampled per packet at decision)
//  pkts_passed  out  CNT_WIDTH   packets forwarded since reset, saturating
//  pkts_dropped out  CNT_WIDTH   packets discarded since reset, saturating
// BEHAVIOUR
//  Reset (reset=0, async): all FIFOs empty, both FSMs to initial state, out_wr=0, counters=0, in_rdy=1
//   after release. Partial packets in flight are discarded.
//  Input parser (on each in_wr, stores word in FIFO): states HDRS -> WORD1 -> WORD2 -> PAYLOAD.
//   HDRS: ctrl!=0 words stay; first ctrl==0 word -> WORD1, save word[15:0] as src_mac[47:32].
//   WORD1: next word -> WORD2 transition; src_mac = {saved[15:0], word[63:32]}; push
//    drop = check_en && (src_mac[40] || src_mac==48'h0) into decision FIFO (same edge as word write).
//   PAYLOAD (entered after WORD2 word): ctrl!=0 word is eop -> HDRS. If WORD2 word itself has ctrl!=0
//    it is eop (decision pushed, -> HDRS).
//   Packets have >=2 data words; 1-data-word packets are out of contract.
//  Output FSM: IDLE, XFER.
//   IDLE: if decision FIFO non-empty -> pop, latch drop, clear seen_data, -> XFER. No word moves in IDLE.
//   XFER: a word moves when !in_fifo_empty && (drop || out_rdy); out_wr = !drop on that cycle.
//    Dropped packets drain at one word/cycle regardless of out_rdy.
//    Moved word with ctrl==0 sets seen_data; moved word with ctrl!=0 && seen_data is eop -> IDLE,
//    increment pkts_dropped (drop) or pkts_passed (!drop), saturate at all-ones.
//  Latency: first header word out no earlier than 1 cycle after second data word written
//   (decision registered, IDLE pop cycle). Back-to-back packets: 1 idle cycle between eop and next header.
//  out_data/out_ctrl valid only when out_wr=1; content otherwise don't-care. Words never modified.
//  Simultaneous parser push and IDLE pop on decision FIFO: both occur; occupancy unchanged.
//  Backpressure: in_wr while in_rdy=0 is an upstream violation; the block need not tolerate it.
// TESTING
//  1 Unicast src 00:11:22:33:44:55, 2 hdrs + 8 data words, out_rdy=1 -> 10 identical words out, pkts_passed=1.
//  2 Src ff:ff:ff:ff:ff:ff then src 01:00:5e:00:00:01 -> no out_wr for either, pkts_dropped=2.
//  3 Src 00:00:00:00:00:00 with check_en=1 dropped; same packet with check_en=0 passed unchanged.
//  4 Pass, drop, pass packets back-to-back, out_rdy toggling random 50% -> only passes emerge, in order, intact.
//  5 out_rdy=0 for 200 cycles under continuous input -> in_rdy falls, no word lost/duplicated after release.
//  6 Assert reset mid-packet -> out_wr=0 immediately, counters=0; next full packet forwarded correctly.

Source files
------------

// File: rtl/as_src_mac_check.sv
// as_src_mac_check: source-MAC sanity filter placed after the anti-spoof port lookup.
// Buffers each packet and holds it until its second data word is seen. Packets whose
// Ethernet source address is group (multicast/broadcast) or all-zero are drained
// silently when check_en is set; every other packet is forwarded word for word.
// Saturating counters track forwarded and discarded packets.
module as_src_mac_check #(
    parameter int DATA_WIDTH          = 64,
    parameter int CTRL_WIDTH          = DATA_WIDTH / 8,
    parameter int IN_FIFO_DEPTH_BITS  = 4,
    parameter int DEC_FIFO_DEPTH_BITS = 2,
    parameter int CNT_WIDTH           = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [CTRL_WIDTH-1:0] in_ctrl,
    input  logic                  in_wr,
    output logic                  in_rdy,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [CTRL_WIDTH-1:0] out_ctrl,
    output logic                  out_wr,
    input  logic                  out_rdy,
    input  logic                  check_en,
    output logic [CNT_WIDTH-1:0]  pkts_passed,
    output logic [CNT_WIDTH-1:0]  pkts_dropped
);

    localparam int IW = IN_FIFO_DEPTH_BITS;
    localparam int DW = DEC_FIFO_DEPTH_BITS;
    localparam int WORD_W = DATA_WIDTH + CTRL_WIDTH;
    localparam int IN_DEPTH = 1 << IW;
    localparam int DEC_DEPTH = 1 << DW;
    // One spare word slot absorbs the write issued in the cycle in_rdy is observed high.
    localparam logic [IW:0] IN_NF_LVL = (IW + 1)'(IN_DEPTH - 2);
    localparam logic [DW:0] DEC_NF_LVL = (DW + 1)'(DEC_DEPTH - 1);
    localparam logic [IW:0] IN_CNT_ONE = {{IW{1'b0}}, 1'b1};
    localparam logic [IW-1:0] IN_PTR_ONE = {{(IW - 1){1'b0}}, 1'b1};
    localparam logic [DW:0] DEC_CNT_ONE = {{DW{1'b0}}, 1'b1};
    localparam logic [DW-1:0] DEC_PTR_ONE = {{(DW - 1){1'b0}}, 1'b1};
    localparam logic [IW:0] IN_CNT_ZERO = {(IW + 1){1'b0}};
    localparam logic [DW:0] DEC_CNT_ZERO = {(DW + 1){1'b0}};
    localparam logic [CTRL_WIDTH-1:0] CTRL_ZERO = {CTRL_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH - 1){1'b0}}, 1'b1};

    // State names follow the last word stored: WORD1/WORD2 = first/second data word seen.
    typedef enum logic [1:0] {P_HDRS = 2'd0, P_WORD1 = 2'd1, P_WORD2 = 2'd2, P_PAYLOAD = 2'd3} p_state_e;
    typedef enum logic {O_IDLE = 1'b0, O_XFER = 1'b1} o_state_e;

    // Group bit (first octet LSB) or the reserved all-zero address marks a spoofed source.
    function automatic logic src_is_bad(input logic [47:0] mac);
        src_is_bad = mac[40] || (mac == 48'h0);
    endfunction

    p_state_e p_state_q, p_state_d;
    o_state_e o_state_q, o_state_d;
    logic [15:0] src_hi_q, src_hi_d;
    logic [WORD_W-1:0] mem_q [IN_DEPTH];
    logic [IW-1:0] in_wr_ptr_q, in_wr_ptr_d, in_rd_ptr_q, in_rd_ptr_d;
    logic [IW:0] in_cnt_q, in_cnt_d;
    logic dec_mem_q [DEC_DEPTH];
    logic [DW-1:0] dec_wr_ptr_q, dec_wr_ptr_d, dec_rd_ptr_q, dec_rd_ptr_d;
    logic [DW:0] dec_cnt_q, dec_cnt_d;
    logic drop_q, drop_d, seen_q, seen_d, in_rdy_q, in_rdy_d, out_wr_q, out_wr_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic [CTRL_WIDTH-1:0] out_ctrl_q, out_ctrl_d;
    logic [CNT_WIDTH-1:0] pass_cnt_q, pass_cnt_d, drop_cnt_q, drop_cnt_d;
    logic dec_push_s, dec_bit_s, dec_pop_s, move_s;
    logic [WORD_W-1:0] head_s;

    assign head_s = mem_q[in_rd_ptr_q];

    // Input parser: locate the source MAC across data words 1 and 2, emit one verdict per packet.
    always_comb begin
        p_state_d = p_state_q;
        src_hi_d = src_hi_q;
        dec_push_s = 1'b0;
        dec_bit_s = 1'b0;
        if (in_wr) begin
            case (p_state_q)
                P_HDRS: begin
                    if (in_ctrl == CTRL_ZERO) begin
                        src_hi_d = in_data[15:0];
                        p_state_d = P_WORD1;
                    end else begin
                        p_state_d = P_HDRS;
                    end
                end
                P_WORD1: begin
                    dec_push_s = 1'b1;
                    dec_bit_s = check_en && src_is_bad({src_hi_q, in_data[63:32]});
                    p_state_d = (in_ctrl != CTRL_ZERO) ? P_HDRS : P_WORD2;
                end
                P_WORD2, P_PAYLOAD: begin
                    p_state_d = (in_ctrl != CTRL_ZERO) ? P_HDRS : P_PAYLOAD;
                end
                default: p_state_d = P_HDRS;
            endcase
        end else begin
            p_state_d = p_state_q;
        end
    end

    // Output FSM: fetch a verdict, then stream (or silently drain) the packet to its eop.
    always_comb begin
        o_state_d = o_state_q;
        drop_d = drop_q;
        seen_d = seen_q;
        dec_pop_s = 1'b0;
        move_s = 1'b0;
        out_wr_d = 1'b0;
        out_data_d = out_data_q;
        out_ctrl_d = out_ctrl_q;
        pass_cnt_d = pass_cnt_q;
        drop_cnt_d = drop_cnt_q;
        case (o_state_q)
            O_IDLE: begin
                if (dec_cnt_q != DEC_CNT_ZERO) begin
                    dec_pop_s = 1'b1;
                    drop_d = dec_mem_q[dec_rd_ptr_q];
                    seen_d = 1'b0;
                    o_state_d = O_XFER;
                end else begin
                    o_state_d = O_IDLE;
                end
            end
            O_XFER: begin
                if ((in_cnt_q != IN_CNT_ZERO) && (drop_q || out_rdy)) begin
                    move_s = 1'b1;
                    out_wr_d = !drop_q;
                    out_data_d = head_s[DATA_WIDTH-1:0];
                    out_ctrl_d = head_s[WORD_W-1:DATA_WIDTH];
                    if (head_s[WORD_W-1:DATA_WIDTH] == CTRL_ZERO) begin
                        seen_d = 1'b1;
                    end else if (seen_q) begin
                        o_state_d = O_IDLE;
                        if (drop_q) begin
                            drop_cnt_d = (drop_cnt_q == CNT_MAX) ? drop_cnt_q : drop_cnt_q + CNT_ONE;
                        end else begin
                            pass_cnt_d = (pass_cnt_q == CNT_MAX) ? pass_cnt_q : pass_cnt_q + CNT_ONE;
                        end
                    end else begin
                        seen_d = seen_q;
                    end
                end else begin
                    move_s = 1'b0;
                end
            end
            default: o_state_d = O_IDLE;
        endcase
    end

    // FIFO bookkeeping for the word buffer and decision queue, plus the registered ready.
    always_comb begin
        in_wr_ptr_d = in_wr ? in_wr_ptr_q + IN_PTR_ONE : in_wr_ptr_q;
        in_rd_ptr_d = move_s ? in_rd_ptr_q + IN_PTR_ONE : in_rd_ptr_q;
        dec_wr_ptr_d = dec_push_s ? dec_wr_ptr_q + DEC_PTR_ONE : dec_wr_ptr_q;
        dec_rd_ptr_d = dec_pop_s ? dec_rd_ptr_q + DEC_PTR_ONE : dec_rd_ptr_q;
        case ({in_wr, move_s})
            2'b10:   in_cnt_d = in_cnt_q + IN_CNT_ONE;
            2'b01:   in_cnt_d = in_cnt_q - IN_CNT_ONE;
            default: in_cnt_d = in_cnt_q;
        endcase
        case ({dec_push_s, dec_pop_s})
            2'b10:   dec_cnt_d = dec_cnt_q + DEC_CNT_ONE;
            2'b01:   dec_cnt_d = dec_cnt_q - DEC_CNT_ONE;
            default: dec_cnt_d = dec_cnt_q;
        endcase
        in_rdy_d = (in_cnt_d < IN_NF_LVL) && (dec_cnt_d < DEC_NF_LVL);
    end

    // Storage arrays: written only, no reset needed since occupancy counters gate every read.
    always_ff @(posedge clk) begin
        if (in_wr) mem_q[in_wr_ptr_q] <= {in_ctrl, in_data};
        if (dec_push_s) dec_mem_q[dec_wr_ptr_q] <= dec_bit_s;
    end

    // State, pointer, counter and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            p_state_q <= P_HDRS;
            o_state_q <= O_IDLE;
            src_hi_q <= 16'h0;
            in_wr_ptr_q <= {IW{1'b0}};
            in_rd_ptr_q <= {IW{1'b0}};
            in_cnt_q <= IN_CNT_ZERO;
            dec_wr_ptr_q <= {DW{1'b0}};
            dec_rd_ptr_q <= {DW{1'b0}};
            dec_cnt_q <= DEC_CNT_ZERO;
            drop_q <= 1'b0;
            seen_q <= 1'b0;
            in_rdy_q <= 1'b1;
            out_wr_q <= 1'b0;
            out_data_q <= {DATA_WIDTH{1'b0}};
            out_ctrl_q <= CTRL_ZERO;
            pass_cnt_q <= {CNT_WIDTH{1'b0}};
            drop_cnt_q <= {CNT_WIDTH{1'b0}};
        end else begin
            p_state_q <= p_state_d;
            o_state_q <= o_state_d;
            src_hi_q <= src_hi_d;
            in_wr_ptr_q <= in_wr_ptr_d;
            in_rd_ptr_q <= in_rd_ptr_d;
            in_cnt_q <= in_cnt_d;
            dec_wr_ptr_q <= dec_wr_ptr_d;
            dec_rd_ptr_q <= dec_rd_ptr_d;
            dec_cnt_q <= dec_cnt_d;
            drop_q <= drop_d;
            seen_q <= seen_d;
            in_rdy_q <= in_rdy_d;
            out_wr_q <= out_wr_d;
            out_data_q <= out_data_d;
            out_ctrl_q <= out_ctrl_d;
            pass_cnt_q <= pass_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign in_rdy = in_rdy_q;
    assign out_wr = out_wr_q;
    assign out_data = out_data_q;
    assign out_ctrl = out_ctrl_q;
    assign pkts_passed = pass_cnt_q;
    assign pkts_dropped = drop_cnt_q;

endmodule

// File: tb/tb_as_src_mac_check.sv
// Directed bench for as_src_mac_check: table of single packets, then hand-written
// back-to-back, backpressure and mid-packet reset sequences. A scoreboard queue holds
// every word that should appear on the output, in order.
module tb_as_src_mac_check;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [63:0] in_data = 64'h0;
    logic [7:0]  in_ctrl = 8'h0;
    logic        in_wr = 1'b0;
    logic        in_rdy;
    logic [63:0] out_data;
    logic [7:0]  out_ctrl;
    logic        out_wr;
    logic        out_rdy = 1'b1;
    logic        check_en = 1'b1;
    logic [31:0] pkts_passed;
    logic [31:0] pkts_dropped;

    as_src_mac_check dut (
        .clk(clk), .reset(reset),
        .in_data(in_data), .in_ctrl(in_ctrl), .in_wr(in_wr), .in_rdy(in_rdy),
        .out_data(out_data), .out_ctrl(out_ctrl), .out_wr(out_wr), .out_rdy(out_rdy),
        .check_en(check_en), .pkts_passed(pkts_passed), .pkts_dropped(pkts_dropped)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [47:0] mac;
        logic        ce;
        int          nhdr;
        int          ndata;
        logic        exp_drop;
    } vec_t;

    vec_t vecs[9];
    logic [71:0] exp_q[$];
    int passed = 0;
    int total = 0;
    int mdl_pass = 0;
    int mdl_drop = 0;
    logic [15:0] seq = 16'h0;
    logic saw_rdy_low = 1'b0;
    logic stim_done = 1'b0;

    function automatic void chk(input string name, input logic [71:0] got, input logic [71:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endfunction

    // Output monitor: every out_wr word must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!in_rdy) saw_rdy_low = 1'b1;
        if (reset && out_wr) begin
            if (exp_q.size() == 0) begin
                total++;
                $display("FAIL unexpected_word: got %0h expected no output", {out_ctrl, out_data});
            end else begin
                chk("out_word", {out_ctrl, out_data}, exp_q.pop_front());
            end
        end
    end

    task automatic put_word(input logic [7:0] c, input logic [63:0] d);
        int guard = 0;
        while (!in_rdy && guard < 2000) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!in_rdy) begin
            total++;
            $display("FAIL in_rdy_timeout: in_rdy stayed %0b, required 1", in_rdy);
        end else begin
            in_ctrl = c; in_data = d; in_wr = 1'b1;
            @(posedge clk); #1;
            in_wr = 1'b0;
        end
    endtask

    // Sends a packet; nsend < 0 sends it whole, otherwise only the first nsend words.
    task automatic send_pkt(input logic [47:0] mac, input logic ce, input int nhdr,
                            input int ndata, input logic exp_drop, input int nsend);
        logic [63:0] d;
        logic [7:0] c;
        int sent = 0;
        int lim = (nsend < 0) ? nhdr + ndata : nsend;
        seq = seq + 16'd1;
        check_en = ce;
        for (int h = 0; h < nhdr; h++) begin
            c = 8'hFF - 8'(h);
            d = {16'hC0DE, seq, 32'(h)};
            if (sent < lim) begin
                if (!exp_drop) exp_q.push_back({c, d});
                put_word(c, d);
                sent++;
            end
        end
        for (int i = 0; i < ndata; i++) begin
            c = (i == ndata - 1) ? 8'h80 : 8'h00;
            d = {16'hDA7A, seq, 16'(i), 16'h5A5A};
            if (i == 0) d[15:0] = mac[47:32];
            if (i == 1) d[63:32] = mac[31:0];
            if (sent < lim) begin
                if (!exp_drop) exp_q.push_back({c, d});
                put_word(c, d);
                sent++;
            end
        end
        if (nsend < 0) begin
            if (exp_drop) mdl_drop++;
            else mdl_pass++;
        end
    endtask

    task automatic wait_drain(input string name);
        int guard = 0;
        while ((pkts_passed != 32'(mdl_pass) || pkts_dropped != 32'(mdl_drop)) && guard < 3000) begin
            @(posedge clk); #1;
            guard++;
        end
        repeat (3) @(posedge clk);
        #1;
        chk({name, "_passed"}, 72'(pkts_passed), 72'(mdl_pass));
        chk({name, "_dropped"}, 72'(pkts_dropped), 72'(mdl_drop));
        chk({name, "_leftover"}, 72'(exp_q.size()), 72'd0);
    endtask

    initial begin
        vecs[0] = '{48'h001122334455, 1'b1, 2, 8, 1'b0};
        vecs[1] = '{48'hFFFFFFFFFFFF, 1'b1, 2, 4, 1'b1};
        vecs[2] = '{48'h01005E000001, 1'b1, 1, 3, 1'b1};
        vecs[3] = '{48'h000000000000, 1'b1, 2, 4, 1'b1};
        vecs[4] = '{48'h000000000000, 1'b0, 2, 4, 1'b0};
        vecs[5] = '{48'h020000000001, 1'b1, 3, 5, 1'b0};
        vecs[6] = '{48'h000000000001, 1'b1, 1, 3, 1'b0};
        vecs[7] = '{48'h010000000000, 1'b0, 2, 3, 1'b0};
        vecs[8] = '{48'h00AABBCCDDEE, 1'b1, 1, 2, 1'b0};

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_wr", 72'(out_wr), 72'd0);
        chk("rst_passed", 72'(pkts_passed), 72'd0);
        chk("rst_dropped", 72'(pkts_dropped), 72'd0);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("rst_in_rdy", 72'(in_rdy), 72'd1);

        // Single packets from the table.
        for (int v = 0; v < 9; v++) begin
            send_pkt(vecs[v].mac, vecs[v].ce, vecs[v].nhdr, vecs[v].ndata, vecs[v].exp_drop, -1);
            wait_drain($sformatf("vec%0d", v));
        end

        // Pass, drop, pass back-to-back with random out_rdy.
        stim_done = 1'b0;
        fork
            begin
                send_pkt(48'h001122334455, 1'b1, 2, 6, 1'b0, -1);
                send_pkt(48'h01005E000001, 1'b1, 2, 6, 1'b1, -1);
                send_pkt(48'h0A0B0C0D0E0F, 1'b1, 1, 5, 1'b0, -1);
                stim_done = 1'b1;
            end
            begin
                while (!stim_done) begin
                    @(posedge clk); #2;
                    out_rdy = 1'($urandom_range(0, 1));
                end
            end
        join
        fork
            begin
                repeat (150) begin
                    @(posedge clk); #2;
                    out_rdy = 1'($urandom_range(0, 1));
                end
                out_rdy = 1'b1;
            end
            wait_drain("b2b");
        join
        out_rdy = 1'b1;

        // Long downstream stall under continuous input.
        saw_rdy_low = 1'b0;
        fork
            begin
                send_pkt(48'h001122334455, 1'b1, 2, 8, 1'b0, -1);
                send_pkt(48'h00DEADBEEF00, 1'b1, 2, 8, 1'b0, -1);
                send_pkt(48'h0000000000AB, 1'b1, 2, 8, 1'b0, -1);
            end
            begin
                out_rdy = 1'b0;
                repeat (200) @(posedge clk);
                #2;
                chk("stall_in_rdy_fell", 72'(saw_rdy_low), 72'd1);
                out_rdy = 1'b1;
            end
        join
        wait_drain("stall");

        // Reset in the middle of a packet, then a clean packet.
        send_pkt(48'h001122334455, 1'b1, 2, 8, 1'b0, 6);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("mid_rst_out_wr", 72'(out_wr), 72'd0);
        chk("mid_rst_passed", 72'(pkts_passed), 72'd0);
        chk("mid_rst_dropped", 72'(pkts_dropped), 72'd0);
        exp_q.delete();
        mdl_pass = 0;
        mdl_drop = 0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_in_rdy", 72'(in_rdy), 72'd1);
        send_pkt(48'h00112233AABB, 1'b1, 2, 5, 1'b0, -1);
        wait_drain("post_rst");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
